// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file constants and index type, reused by the pipeline and decoder.
package legv8_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int XZR_IDX        = 31;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: XZR zeroing, array select and, with REGFILE_BYPASS_EN,
// write-to-read forwarding.
module reg_file_read_port #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]                           rd_idx,
  input  logic [(1<<ADDR_WIDTH)-2:0][DATA_WIDTH-1:0]      regs,
`ifdef REGFILE_BYPASS_EN
  input  logic                                            byp_en,
  input  logic [ADDR_WIDTH-1:0]                           wr_idx,
  input  logic [DATA_WIDTH-1:0]                           wr_data,
`endif
  output logic [DATA_WIDTH-1:0]                           rd_data
);
  localparam logic [ADDR_WIDTH-1:0] XZR = '1;

  always_comb begin
    rd_data = '0;
    if (rd_idx != XZR) rd_data = regs[rd_idx];
`ifdef REGFILE_BYPASS_EN
    // XZR is never forwarded; byp_en already folds in reset and write enable.
    if (byp_en && rd_idx != XZR && wr_idx == rd_idx) rd_data = wr_data;
`endif
  end
endmodule

// File: rtl/reg_file.sv
// LEGv8 register file: X0-X30 storage, hard-wired XZR, two combinational read ports and
// one clocked write port. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module reg_file
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);
  localparam int                    NUM_REGS = (1 << ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] XZR      = '1;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (RegWrite && WriteReg != XZR) regs_d[WriteReg] = WriteData;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = RegWrite & Rst_n;
`endif

  reg_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd1 (
    .rd_idx  (ReadReg1),
    .regs    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .byp_en  (byp_en),
    .wr_idx  (WriteReg),
    .wr_data (WriteData),
`endif
    .rd_data (ReadData1)
  );

  reg_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd2 (
    .rd_idx  (ReadReg2),
    .regs    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .byp_en  (byp_en),
    .wr_idx  (WriteReg),
    .wr_data (WriteData),
`endif
    .rd_data (ReadData2)
  );
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus random traffic against an array model.
module tb_reg_file;
  import legv8_pkg::*;

  logic        Clk, Rst_n, RegWrite;
  reg_idx_t    ReadReg1, ReadReg2, WriteReg;
  logic [63:0] WriteData, ReadData1, ReadData2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] model [32];

  reg_file dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input int idx);
    if (idx == XZR_IDX) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (Rst_n && RegWrite && int'(WriteReg) == idx) return WriteData;
`endif
    return model[idx];
  endfunction

  // Drive one cycle's inputs just after a rising edge, check reads at the falling edge,
  // then retire the write into the model at the next rising edge.
  task automatic cycle(input logic we, input int wr, input logic [63:0] wd,
                       input int r1, input int r2, input string tag);
    RegWrite  = we;
    WriteReg  = reg_idx_t'(wr);
    WriteData = wd;
    ReadReg1  = reg_idx_t'(r1);
    ReadReg2  = reg_idx_t'(r2);
    @(negedge Clk);
    check($sformatf("%s_rd1[%0d]", tag, r1), ReadData1, exp_rd(r1));
    check($sformatf("%s_rd2[%0d]", tag, r2), ReadData2, exp_rd(r2));
    @(posedge Clk);
    if (we && wr != XZR_IDX) model[wr] = wd;
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = 5'd4; ReadReg2 = 5'd30;
    foreach (model[i]) model[i] = 64'd0;
    #2;
    check("por_rd1", ReadData1, 64'd0);
    check("por_rd2", ReadData2, 64'd0);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;

    cycle(1, 3, 64'h0123_4567_89AB_CDEF, 0, 1, "wr_x3");
    cycle(0, 0, 64'd0, 3, 3, "rd_x3");
    check("x3_const", ReadData1, 64'h0123_4567_89AB_CDEF);

    cycle(1, 7, 64'h11, 0, 0, "wr_x7");
    cycle(0, 7, 64'h55, 7, 7, "we_off");
    cycle(0, 0, 64'd0, 7, 3, "rd_x7");
    check("x7_kept", ReadData1, 64'h11);

    cycle(1, 9, 64'hAA, 0, 0, "wr_x9");
    cycle(1, 9, 64'hBB, 9, 9, "rdw_x9");
    cycle(0, 0, 64'd0, 9, 31, "post_x9");
    check("x9_new", ReadData1, 64'hBB);

    for (int i = 0; i < 31; i++) cycle(1, i, 64'(i) * 64'h1000_0001, 31 - i, i, "sweep_wr");
    for (int i = 0; i < 32; i++) cycle(0, 0, 64'd0, i, 31 - i, "sweep_rd");

    cycle(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, "xzr_wr");
    check("xzr_rd2", ReadData2, 64'd0);
    for (int i = 0; i < 32; i++) cycle(0, 0, 64'd0, i, i, "xzr_keep");

    for (int n = 0; n < 300; n++) begin
      logic [63:0] d;
      int wr;
      d  = {$urandom, $urandom};
      wr = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), wr, d,
            int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, 31)),
            "rand");
    end

    // Reset mid-run must clear reads immediately, with no clock edge, and win over a write edge.
    cycle(1, 5, 64'hDEAD, 0, 0, "wr_x5");
    ReadReg1 = 5'd5; ReadReg2 = 5'd3; RegWrite = 1'b0;
    @(negedge Clk); #1;
    check("x5_pre_rst", ReadData1, 64'hDEAD);
    #1 Rst_n = 1'b0;
    #1;
    check("rst_async_rd1", ReadData1, 64'd0);
    check("rst_async_rd2", ReadData2, 64'd0);
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'h1234;
    @(posedge Clk); #1;
    check("rst_prio_rd1", ReadData1, 64'd0);
    foreach (model[i]) model[i] = 64'd0;
    @(negedge Clk); Rst_n = 1'b1; RegWrite = 1'b0;
    @(posedge Clk); #1;
    cycle(1, 5, 64'hCAFE, 5, 3, "post_rst_wr");
    cycle(0, 0, 64'd0, 5, 12, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
